// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the add/sub controller state type.
package kyber_pkg;

    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned KYBER_N = 256;
    localparam int unsigned COEF_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/cla_adder.sv
// W-bit carry-lookahead adder producing a (W+1)-bit sum.
module cla_adder #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum = {c[W], p ^ c[W-1:0]};
    end

endmodule

// File: rtl/mod_q_reduce.sv
// Single conditional subtract of Q: maps [0, 2Q-2] onto [0, Q-1].
module mod_q_reduce
    import kyber_pkg::*;
#(
    parameter int unsigned W = 12,
    parameter int unsigned Q = KYBER_Q
) (
    input  logic [W:0]   sum,
    output logic [W-1:0] r
);

    always_comb begin
        r = (sum >= (W+1)'(Q)) ? W'(sum - (W+1)'(Q)) : W'(sum);
    end

endmodule

// File: rtl/poly_addsub_ctrl.sv
// Streams a full polynomial through one adder: wr = (a +/- b) mod Q,
// read at cycle k, reduced and registered, written at cycle k+2.
module poly_addsub_ctrl #(
    parameter int unsigned N_COEF = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned Q      = 3329
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [COEF_W-1:0] rd_data_a,
    input  logic [COEF_W-1:0] rd_data_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COEF_W-1:0] wr_data
);

    import kyber_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEF - 1);

    ctrl_state_t       state, state_next;
    logic [ADDR_W-1:0] cnt;
    logic              drain_cnt;
    logic              mode_q;
    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [COEF_W-1:0] b_op;
    logic [COEF_W:0]   sum;
    logic [COEF_W-1:0] red;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= 1'b0;
            mode_q    <= 1'b0;
            vld_q     <= 1'b0;
            addr_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                mode_q <= mode;
                cnt    <= '0;
            end
            // Counter stops on the last address so rd_addr holds it until the next start
            if (state == RUN && cnt != LAST_ADDR) begin
                cnt <= cnt + ADDR_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            vld_q     <= rd_en;
            addr_q    <= rd_addr;
            wr_en     <= vld_q;
            if (vld_q) begin
                wr_addr <= addr_q;
                wr_data <= red;
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        rd_en      = (state == RUN);
        rd_addr    = cnt;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_ADDR) state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtract is a + (Q - b); b = 0 must map to 0, not Q
    always_comb begin
        b_op = rd_data_b;
        if (mode_q) begin
            b_op = (rd_data_b == '0) ? '0 : COEF_W'(Q) - rd_data_b;
        end
    end

    cla_adder #(
        .W(COEF_W)
    ) u_add (
        .a  (rd_data_a),
        .b  (b_op),
        .sum(sum)
    );

    mod_q_reduce #(
        .W(COEF_W),
        .Q(Q)
    ) u_red (
        .sum(sum),
        .r  (red)
    );

endmodule
